multdiv_unit: RTL

//  Multi-cycle signed 32-bit multiply/divide unit in the execute stage, directly downstream of the

---
 rtl/multdiv_pkg.sv | 27 ++
 rtl/multdiv_unit_div_step.sv | 25 ++
 rtl/multdiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
// BOOTH_RADIX4_EN halves the multiply iteration count (radix-4 Booth).
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int XLEN = 32;

`ifdef BOOTH_RADIX4_EN
  localparam int ITER_MULT = XLEN / 2;
`else
  localparam int ITER_MULT = XLEN;
`endif
  localparam int ITER_DIV = XLEN;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // The remainder is always below the divisor, so the shifted value fits in
  // WIDTH bits and the top bit of the difference is a clean borrow flag.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign o_q     = !w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit feeding the execute stage.
// Define BOOTH_RADIX4_EN for a radix-4 Booth multiply (WIDTH/2 iterations).
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef BOOTH_RADIX4_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  state_e             r_state, w_nstate;
  op_e                r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [2*WIDTH-1:0] r_a, r_acc;
  logic [BW-1:0]      r_b;
  logic [2*WIDTH-1:0] w_pp, w_macc, w_prod;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem, w_quo;
  logic               w_qbit, w_start, w_dbz, w_last;

  assign w_start = (r_state != RUN) && (ctrl_mult || ctrl_div);
  assign w_dbz   = !ctrl_mult && (data_operandB == '0);
  assign w_last  = (r_cnt == CNT_W'(((r_op == OP_MULT) ? ITER_MULT : ITER_DIV) - 1));
  assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef BOOTH_RADIX4_EN
  // r_b holds {multiplier, 0}; its low three bits select the Booth digit.
  always_comb begin
    w_pp = '0;
    case (r_b[2:0])
      3'b001, 3'b010: w_pp = r_a;
      3'b011:         w_pp = r_a << 1;
      3'b100:         w_pp = -(r_a << 1);
      3'b101, 3'b110: w_pp = -r_a;
      default:        w_pp = '0;
    endcase
  end
  assign w_macc = r_acc + w_pp;
  assign w_prod = w_macc;
`else
  assign w_pp   = r_b[0] ? r_a : '0;
  assign w_macc = r_acc + w_pp;
  assign w_prod = r_sign ? -w_macc : w_macc;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_acc[WIDTH-1:0]),
    .i_bit (r_a[WIDTH-1]),
    .i_dvs (r_b[WIDTH-1:0]),
    .o_rem (w_rem),
    .o_q   (w_qbit)
  );
  assign w_quo = {r_a[WIDTH-2:0], w_qbit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE, DONE: w_nstate = w_start ? (w_dbz ? DONE : RUN) : IDLE;
      RUN:        if (w_last) w_nstate = DONE;
      default:    w_nstate = IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == RUN);
    data_resultRDY = (r_state == DONE);
  end

  // Divide reuses r_a as a dividend/quotient shift register and r_acc as the remainder.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_op           <= OP_MULT;
      r_sign         <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_acc          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= '0;
      r_op   <= ctrl_mult ? OP_MULT : OP_DIV;
      r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_acc  <= '0;
      if (ctrl_mult) begin
`ifdef BOOTH_RADIX4_EN
        r_a <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        r_b <= {data_operandB, 1'b0};
`else
        r_a <= {{WIDTH{1'b0}}, w_abs_a};
        r_b <= w_abs_b;
`endif
      end else begin
        r_a <= {{WIDTH{1'b0}}, w_abs_a};
        r_b <= BW'(w_abs_b);
      end
      if (w_dbz) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_op == OP_MULT) begin
        r_acc <= w_macc;
`ifdef BOOTH_RADIX4_EN
        r_a <= r_a << 2;
        r_b <= {{2{r_b[BW-1]}}, r_b[BW-1:2]};
`else
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
`endif
        if (w_last) begin
          data_result    <= w_prod[WIDTH-1:0];
          data_exception <= !((w_prod[2*WIDTH-1:WIDTH-1] == '0) ||
                              (w_prod[2*WIDTH-1:WIDTH-1] == '1));
        end
      end else begin
        r_acc <= {{WIDTH{1'b0}}, w_rem};
        r_a   <= {r_a[2*WIDTH-2:0], w_qbit};
        if (w_last) begin
          // Only MIN_INT / -1 yields a positive quotient with the MSB set.
          data_result    <= r_sign ? -w_quo : w_quo;
          data_exception <= !r_sign && (w_quo == MIN_INT);
        end
      end
    end
  end

endmodule
